// File: rtl/io_write_sequencer.sv
// io_write_sequencer: Avalon-MM slave that sends one two-word command to the
// external I/O controller. The command is latched, the controller FIFO is
// waited on with a timeout, then out_we is pulsed with timed setup/hold phases.
module io_write_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 1,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic              in_full,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              out_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [DATA_W-1:0]  data_a, data_b;
    logic               irq_en;
    logic               done, timeout, overrun;
    logic               busy;

    logic               reg_wr;
    logic               start_wr;
    logic [2:0]         w1c;
    logic               load_shadow;
    logic               set_done, set_timeout, set_overrun;

    assign reg_wr      = chipselect & ~write_n;
    assign start_wr    = reg_wr && (address == 2'd2) && writedata[0];
    assign w1c         = (reg_wr && (address == 2'd3)) ? writedata[3:1] : '0;
    assign busy        = (state != S_IDLE);
    assign set_overrun = start_wr && busy;
    assign irq         = irq_en & (done | timeout);

    // Next-state, phase counter and event strobes for the write sequence
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        load_shadow = 1'b0;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_wr) begin
                    load_shadow = 1'b1;
                    cnt_next    = '0;
                    next_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!in_full) begin
                    cnt_next   = '0;
                    next_state = S_SETUP;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cnt_next    = '0;
                    set_timeout = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_next   = '0;
                    next_state = S_STROBE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt == CNT_W'(PULSE_CYC - 1)) begin
                    cnt_next   = '0;
                    next_state = S_HOLD;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    cnt_next   = '0;
                    set_done   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                next_state = S_IDLE;
            end
        endcase
    end

    // FSM state, counter, shadow command words and registered write enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out_data_a <= '0;
            out_data_b <= '0;
            out_we     <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            // registered from next_state so out_we is high exactly while in STROBE
            out_we <= (next_state == S_STROBE);
            if (load_shadow) begin
                out_data_a <= data_a;
                out_data_b <= data_b;
            end
        end
    end

    // CPU-visible registers; sticky status bits favour a set over a W1C clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a  <= '0;
            data_b  <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (reg_wr && (address == 2'd0)) data_a <= DATA_W'(writedata);
            if (reg_wr && (address == 2'd1)) data_b <= DATA_W'(writedata);
            if (reg_wr && (address == 2'd2)) irq_en <= writedata[1];
            done    <= set_done    | (done    & ~w1c[0]);
            timeout <= set_timeout | (timeout & ~w1c[1]);
            overrun <= set_overrun | (overrun & ~w1c[2]);
        end
    end

    // Combinational read mux
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = 32'(data_a);
            2'd1: readdata = 32'(data_b);
            2'd2: readdata = {30'd0, irq_en, 1'b0};
            2'd3: readdata = {28'd0, overrun, timeout, done, busy};
            default: readdata = '0;
        endcase
    end

endmodule
